// File: rtl/n_term_cfg_tile_pkg.sv
// rtl/n_term_cfg_tile_pkg.sv - select codes, wire-group widths and config layout for n_term_cfg_tile
package n_term_cfg_tile_pkg;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_N1   = 2'b01;
  localparam logic [1:0] SEL_N2   = 2'b10;
  localparam logic [1:0] SEL_N4   = 2'b11;

  localparam int N1_W = 4;
  localparam int N2_W = 8;
  localparam int N4_W = 16;

  localparam int CFG_BITS = 72;

  // Output index of the first select field of each group, LSB-first.
  localparam int S1_OFS  = 0;
  localparam int S2_OFS  = S1_OFS + N1_W;
  localparam int S2B_OFS = S2_OFS + N2_W;
  localparam int S4_OFS  = S2B_OFS + N2_W;

  function automatic logic route_bit(input logic [1:0] sel, input logic n1,
                                     input logic n2, input logic n4);
    case (sel)
      SEL_N1:  return n1;
      SEL_N2:  return n2;
      SEL_N4:  return n4;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/n_term_cfg_tile_frame_pipe.sv
// rtl/n_term_cfg_tile_frame_pipe.sv - n_term_cfg_frame_pipe: 0..2 stage repeater for frame data/strobe
module n_term_cfg_frame_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (STAGES < 0 || STAGES > 2) begin : g_bad_stages
    $error("n_term_cfg_frame_pipe: STAGES must be 0..2");
  end

  if (STAGES == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign dout = din;
  end else begin : g_regs
    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
      end else begin
        stage_q[0] <= din;
        for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
      end
    end

    assign dout = stage_q[STAGES-1];
  end

endmodule

// File: rtl/n_term_cfg_tile.sv
// rtl/n_term_cfg_tile.sv - north-terminating config tile; optional parity via CFG_PARITY_EN
module n_term_cfg_tile
  import n_term_cfg_tile_pkg::*;
#(
  parameter int FRAME_BITS_PER_ROW = 32,
  parameter int MAX_FRAMES_PER_COL = 20,
  parameter int PIPE_STAGES        = 1,
  parameter int NUM_CFG_FRAMES     = 3,
  parameter int CFG_FRAME_BASE     = 0
) (
  input  logic                          CLK,
  input  logic                          resetn,
  input  logic [N1_W-1:0]               N1END,
  input  logic [N2_W-1:0]               N2MID,
  input  logic [N2_W-1:0]               N2END,
  input  logic [N4_W-1:0]               N4END,
  output logic [N1_W-1:0]               S1BEG,
  output logic [N2_W-1:0]               S2BEG,
  output logic [N2_W-1:0]               S2BEGb,
  output logic [N4_W-1:0]               S4BEG,
  input  logic [FRAME_BITS_PER_ROW-1:0] FrameData,
  input  logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
  output logic [FRAME_BITS_PER_ROW-1:0] FrameData_O,
  output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe_O,
`ifdef CFG_PARITY_EN
  output logic                          CfgParityErr,
`endif
  output logic                          CfgValid
);

  localparam int CFG_BUS_W = NUM_CFG_FRAMES * FRAME_BITS_PER_ROW;

  if (CFG_BUS_W < CFG_BITS) begin : g_err_size
    $error("n_term_cfg_tile: local frames cannot hold 72 config bits");
  end
  if (CFG_FRAME_BASE + NUM_CFG_FRAMES > MAX_FRAMES_PER_COL) begin : g_err_base
    $error("n_term_cfg_tile: local strobes exceed FrameStrobe width");
  end

  n_term_cfg_frame_pipe #(.WIDTH(FRAME_BITS_PER_ROW), .STAGES(PIPE_STAGES)) u_data_pipe (
    .clk  (CLK),
    .rst_n(resetn),
    .din  (FrameData),
    .dout (FrameData_O)
  );

  n_term_cfg_frame_pipe #(.WIDTH(MAX_FRAMES_PER_COL), .STAGES(PIPE_STAGES)) u_strobe_pipe (
    .clk  (CLK),
    .rst_n(resetn),
    .din  (FrameStrobe),
    .dout (FrameStrobe_O)
  );

  logic [NUM_CFG_FRAMES-1:0] local_strobe;
  logic [NUM_CFG_FRAMES-1:0] strobe_prev_q;
  logic [NUM_CFG_FRAMES-1:0] load;
  logic [NUM_CFG_FRAMES-1:0] loaded_q;
  logic [NUM_CFG_FRAMES-1:0][FRAME_BITS_PER_ROW-1:0] frame_q;
  logic [CFG_BUS_W-1:0] cfg_bus;
  logic [CFG_BITS-1:0]  cfg;

  assign local_strobe = FrameStrobe[CFG_FRAME_BASE +: NUM_CFG_FRAMES];
  // History resets low so a strobe already high at reset release loads once.
  assign load = local_strobe & ~strobe_prev_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      strobe_prev_q <= '0;
      loaded_q      <= '0;
      frame_q       <= '0;
      CfgValid      <= 1'b0;
    end else begin
      strobe_prev_q <= local_strobe;
      loaded_q      <= loaded_q | load;
      CfgValid      <= CfgValid | (&(loaded_q | load));
      for (int f = 0; f < NUM_CFG_FRAMES; f++) begin
        if (load[f]) frame_q[f] <= FrameData;
      end
    end
  end

  assign cfg_bus = frame_q;
  assign cfg     = cfg_bus[CFG_BITS-1:0];

  if (CFG_BUS_W > CFG_BITS) begin : g_spare
    logic unused_spare_bits;
    assign unused_spare_bits = ^cfg_bus[CFG_BUS_W-1:CFG_BITS];
  end

  // S1BEG and S2BEGb take their 2-hop source from N2MID, the others from N2END.
  for (genvar i = 0; i < N1_W; i++) begin : g_s1
    assign S1BEG[i] = route_bit(cfg[2*(S1_OFS+i) +: 2], N1END[i % N1_W],
                                N2MID[i % N2_W], N4END[i % N4_W]);
  end
  for (genvar i = 0; i < N2_W; i++) begin : g_s2
    assign S2BEG[i]  = route_bit(cfg[2*(S2_OFS+i) +: 2], N1END[i % N1_W],
                                 N2END[i % N2_W], N4END[i % N4_W]);
    assign S2BEGb[i] = route_bit(cfg[2*(S2B_OFS+i) +: 2], N1END[i % N1_W],
                                 N2MID[i % N2_W], N4END[i % N4_W]);
  end
  for (genvar i = 0; i < N4_W; i++) begin : g_s4
    assign S4BEG[i] = route_bit(cfg[2*(S4_OFS+i) +: 2], N1END[i % N1_W],
                                N2END[i % N2_W], N4END[i % N4_W]);
  end

`ifdef CFG_PARITY_EN
  logic [NUM_CFG_FRAMES-1:0] par_q;
  logic [NUM_CFG_FRAMES-1:0] par_err_q;

  // Per-frame sticky error so reloading a frame clears only its own fault.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      par_q     <= '0;
      par_err_q <= '0;
    end else begin
      for (int f = 0; f < NUM_CFG_FRAMES; f++) begin
        if (load[f]) begin
          par_q[f]     <= ^FrameData;
          par_err_q[f] <= 1'b0;
        end else if ((^frame_q[f]) != par_q[f]) begin
          par_err_q[f] <= 1'b1;
        end
      end
    end
  end

  assign CfgParityErr = |par_err_q;
`endif

endmodule
